roi_io_shifter: RTL

Serial stimulus/response adapter for the fuzzer ROI. It deserialises a one-bit stimulus stream into the wide `din` bus consumed by the DSP ROI and holds that bus stable. After a programmable settle time it captures the ROI's 32-bit `dout` and serialises it back out. It sits in the fuzzer top between the few package pins and the ROI, so an arbitrarily wide ROI input needs only a handful of IOBs.

---
 rtl/roi_io_shifter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/roi_io_shifter.sv
// Serial stimulus/response adapter for the fuzzer ROI. It loads a wide din frame MSB-first from a
// one-bit stream, waits a settle time, captures dout and shifts it back out MSB-first.
module roi_io_shifter #(
    parameter int DIN_W     = 184,
    parameter int DOUT_W    = 32,
    parameter int CAP_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_valid,
    output logic              sin_ready,
    output logic [DIN_W-1:0]  din,
    input  logic [DOUT_W-1:0] dout,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_done
);

    localparam int BCNT_W = $clog2(DIN_W + 1);
    localparam int OCNT_W = $clog2(DOUT_W + 1);
    localparam int SCNT_W = (CAP_DELAY > 1) ? $clog2(CAP_DELAY) : 1;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        SHIFT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    // Only the low DIN_W-1 bits are kept; the final bit goes straight from sin into din.
    logic [DIN_W-2:0]    shreg_q, shreg_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIN_W-1:0]    din_q, din_d;
    logic [SCNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DOUT_W-1:0]   oshr_q, oshr_d;
    logic [OCNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic                sout_q, sout_d;
    logic                sout_valid_q, sout_valid_d;
    logic                frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            din_q        <= '0;
            settle_cnt_q <= '0;
            oshr_q       <= '0;
            out_cnt_q    <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            din_q        <= din_d;
            settle_cnt_q <= settle_cnt_d;
            oshr_q       <= oshr_d;
            out_cnt_q    <= out_cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        din_d        = din_q;
        settle_cnt_d = settle_cnt_q;
        oshr_d       = oshr_q;
        out_cnt_d    = out_cnt_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            LOAD: begin
                if (sin_valid) begin
                    shreg_d = (DIN_W-1)'({shreg_q, sin});
                    if (bit_cnt_q == BCNT_W'(DIN_W - 1)) begin
                        // Whole frame committed at once so the ROI never sees a partial din.
                        din_d     = {shreg_q, sin};
                        bit_cnt_d = '0;
                        state_d   = SETTLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end

            SETTLE: begin
                if (settle_cnt_q == SCNT_W'(CAP_DELAY - 1)) begin
                    oshr_d       = dout << 1;
                    sout_d       = dout[DOUT_W-1];
                    sout_valid_d = 1'b1;
                    out_cnt_d    = OCNT_W'(1);
                    settle_cnt_d = '0;
                    state_d      = SHIFT;
                end else begin
                    settle_cnt_d = settle_cnt_q + SCNT_W'(1);
                end
            end

            SHIFT: begin
                if (out_cnt_q < OCNT_W'(DOUT_W)) begin
                    sout_d    = oshr_q[DOUT_W-1];
                    oshr_d    = oshr_q << 1;
                    out_cnt_d = out_cnt_q + OCNT_W'(1);
                end else begin
                    sout_valid_d = 1'b0;
                    frame_done_d = 1'b1;
                    out_cnt_d    = '0;
                    state_d      = LOAD;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign sin_ready  = (state_q == LOAD);
    assign din        = din_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign frame_done = frame_done_q;

endmodule
